// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller for an external dual-port memory with registered read.
// Optional occupancy output is enabled by defining FIFO_CTRL_LEVEL_EN.
module fifo_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_W+1:0] level
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [ADDR_W:0] mem_cnt;
    logic            full, empty_mem, push, pop, fetch;

    always_comb begin
        mem_cnt   = wr_ptr_q - rd_ptr_q;
        full      = (mem_cnt == (ADDR_W+1)'(DEPTH));
        empty_mem = (wr_ptr_q == rd_ptr_q);
        push      = wr_valid & ~full;
        pop       = out_valid_q & rd_ready;
        // Refill the output stage when it is empty or being drained this cycle.
        fetch     = ~empty_mem & (~out_valid_q | pop);

        wr_ptr_d    = push  ? wr_ptr_q + (ADDR_W+1)'(1) : wr_ptr_q;
        rd_ptr_d    = fetch ? rd_ptr_q + (ADDR_W+1)'(1) : rd_ptr_q;
        out_valid_d = fetch ? 1'b1 : (pop ? 1'b0 : out_valid_q);
    end

    always_comb begin
        wr_ready   = ~full;
        rd_valid   = out_valid_q;
        rd_data    = mem_r_data;
        mem_w_en   = push & ~rst;
        mem_w_addr = wr_ptr_q[ADDR_W-1:0];
        mem_w_data = wr_data;
        mem_r_en   = fetch & ~rst;
        mem_r_addr = rd_ptr_q[ADDR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef FIFO_CTRL_LEVEL_EN
    logic [ADDR_W:0]   mem_cnt_d;
    logic [ADDR_W+1:0] level_d, level_q;

    // Built from next-state values so level always matches the current registered contents.
    always_comb begin
        mem_cnt_d = wr_ptr_d - rd_ptr_d;
        level_d   = {1'b0, mem_cnt_d} + (ADDR_W+2)'(out_valid_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

endmodule
